// File: rtl/dnpcie_aurora_pkg.sv
// Shared constants for the Aurora TX arbiter: state encoding and stream widths.
package dnpcie_aurora_pkg;

   // Width of one Aurora user-interface word and its keep field.
   localparam int WORD_W = 16;
   localparam int KEEP_W = 2;

   // Arbiter state encoding.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      FLUSH = 2'd2
   } state_t;

   // Index width needed to name one of n sources (at least 1 bit).
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/dnpcie_aurora_rr_picker.sv
// Combinational round-robin picker: scans requests starting one past the
// previous winner and returns the first requester as one-hot plus index.
module dnpcie_aurora_rr_picker
   import dnpcie_aurora_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int IW      = idx_width(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] i_req,
   input  logic [IW-1:0]      i_last_idx,
   output logic [NUM_SRC-1:0] o_onehot,
   output logic [IW-1:0]      o_idx,
   output logic               o_any
);

   logic [IW:0]   w_sum;
   logic [IW-1:0] w_cand;

   // Walk last_idx+1 .. last_idx+NUM_SRC modulo NUM_SRC; first hit wins.
   always_comb begin
      o_onehot = '0;
      o_idx    = '0;
      o_any    = 1'b0;
      w_sum    = '0;
      w_cand   = '0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         w_sum = {1'b0, i_last_idx} + (IW+1)'(k);
         if (w_sum >= (IW+1)'(NUM_SRC)) begin
            w_sum = w_sum - (IW+1)'(NUM_SRC);
         end
         w_cand = w_sum[IW-1:0];
         if (!o_any && i_req[w_cand]) begin
            o_any            = 1'b1;
            o_idx            = w_cand;
            o_onehot[w_cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dnpcie_aurora_tx_arbiter.sv
// Packet-level round-robin arbiter in front of the 16-bit Aurora TX port.
// Holds a grant from first beat to tlast, truncates oversize packets, and
// drains the granted source when the channel drops mid-packet.
//
// Handshake: a beat on any stream is a cycle where tvalid and tready are both
// high at the rising edge of user_clk; data is zero-latency pass-through from
// the granted source, and tvalid never depends on tready.
module dnpcie_aurora_tx_arbiter
   import dnpcie_aurora_pkg::*;
#(
   parameter int NUM_SRC       = 4,
   parameter int MAX_PKT_WORDS = 512
) (
   input  logic                      user_clk,
   input  logic                      ur_ch_reset,
   input  logic                      channel_up,
   input  logic [WORD_W*NUM_SRC-1:0] s_axis_tdata,
   input  logic [KEEP_W*NUM_SRC-1:0] s_axis_tkeep,
   input  logic [NUM_SRC-1:0]        s_axis_tlast,
   input  logic [NUM_SRC-1:0]        s_axis_tvalid,
   output logic [NUM_SRC-1:0]        s_axis_tready,
   output logic [0:WORD_W-1]         m_axi_tx_tdata,
   output logic [0:KEEP_W-1]         m_axi_tx_tkeep,
   output logic                      m_axi_tx_tvalid,
   input  logic                      m_axi_tx_tready,
   output logic                      m_axi_tx_tlast,
   output logic [NUM_SRC-1:0]        grant,
   output logic                      trunc_err,
   output logic                      flush_err,
   output state_t                    dbg_state
);

   localparam int          IW        = idx_width(NUM_SRC);
   localparam logic [15:0] LAST_WORD = 16'(MAX_PKT_WORDS - 1);

   state_t               r_state;
   logic [NUM_SRC-1:0]   r_grant;
   logic [IW-1:0]        r_last_idx;
   logic [15:0]          r_wcnt;
   logic                 r_trunc_err;
   logic                 r_flush_err;

   logic [NUM_SRC-1:0]   w_pick_onehot;
   logic [IW-1:0]        w_pick_idx;
   logic                 w_pick_any;
   logic                 w_src_valid;
   logic                 w_src_last;
   logic                 w_at_limit;
   logic                 w_beat;

   dnpcie_aurora_rr_picker #(
      .NUM_SRC (NUM_SRC),
      .IW      (IW)
   ) u_picker (
      .i_req      (s_axis_tvalid),
      .i_last_idx (r_last_idx),
      .o_onehot   (w_pick_onehot),
      .o_idx      (w_pick_idx),
      .o_any      (w_pick_any)
   );

   // While a grant is held, last_idx is the granted source index.
   assign w_src_valid = s_axis_tvalid[r_last_idx];
   assign w_src_last  = s_axis_tlast[r_last_idx];
   assign w_at_limit  = (r_wcnt == LAST_WORD);
   assign w_beat      = (r_state == SEND) && w_src_valid && m_axi_tx_tready;

   assign grant     = r_grant;
   assign trunc_err = r_trunc_err;
   assign flush_err = r_flush_err;
   assign dbg_state = r_state;

   // Pass-through datapath and per-state handshake steering.
   always_comb begin
      m_axi_tx_tdata  = s_axis_tdata[WORD_W*r_last_idx +: WORD_W];
      m_axi_tx_tkeep  = s_axis_tkeep[KEEP_W*r_last_idx +: KEEP_W];
      m_axi_tx_tvalid = 1'b0;
      m_axi_tx_tlast  = 1'b0;
      s_axis_tready   = '0;
      case (r_state)
         SEND: begin
            m_axi_tx_tvalid             = w_src_valid;
            // The beat that reaches the length limit closes the packet.
            m_axi_tx_tlast              = w_src_last | w_at_limit;
            s_axis_tready[r_last_idx]   = m_axi_tx_tready;
         end
         FLUSH: begin
            // Discard the rest of the source packet so it cannot stall.
            s_axis_tready[r_last_idx]   = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Arbitration state machine with registered error pulses.
   always_ff @(posedge user_clk) begin
      if (ur_ch_reset) begin
         r_state     <= IDLE;
         r_grant     <= '0;
         r_last_idx  <= IW'(NUM_SRC - 1);
         r_wcnt      <= '0;
         r_trunc_err <= 1'b0;
         r_flush_err <= 1'b0;
      end else begin
         r_trunc_err <= 1'b0;
         r_flush_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (channel_up && w_pick_any) begin
                  r_grant    <= w_pick_onehot;
                  r_last_idx <= w_pick_idx;
                  r_wcnt     <= '0;
                  r_state    <= SEND;
               end
            end
            SEND: begin
               if (!channel_up) begin
                  // Link loss outranks any beat in the same cycle.
                  r_flush_err <= 1'b1;
                  r_state     <= FLUSH;
               end else if (w_beat) begin
                  if (r_wcnt != 16'hFFFF) begin
                     r_wcnt <= r_wcnt + 16'd1;
                  end
                  if (w_src_last) begin
                     r_grant <= '0;
                     r_state <= IDLE;
                  end else if (w_at_limit) begin
                     r_trunc_err <= 1'b1;
                     r_state     <= FLUSH;
                  end
               end
            end
            FLUSH: begin
               if (w_src_valid && w_src_last) begin
                  r_grant <= '0;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_grant <= '0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dnpcie_aurora_tx_arbiter.sv
// Directed bench for dnpcie_aurora_tx_arbiter: round-robin order, backpressure,
// truncation, link drop with drain, and mid-packet reset.
module tb_dnpcie_aurora_tx_arbiter;
   import dnpcie_aurora_pkg::*;

   localparam int NUM_SRC = 4;
   localparam int MAXW    = 8;

   logic                      user_clk;
   logic                      ur_ch_reset;
   logic                      channel_up;
   logic [16*NUM_SRC-1:0]     s_axis_tdata;
   logic [2*NUM_SRC-1:0]      s_axis_tkeep;
   logic [NUM_SRC-1:0]        s_axis_tlast;
   logic [NUM_SRC-1:0]        s_axis_tvalid;
   logic [NUM_SRC-1:0]        s_axis_tready;
   logic [0:15]               m_axi_tx_tdata;
   logic [0:1]                m_axi_tx_tkeep;
   logic                      m_axi_tx_tvalid;
   logic                      m_axi_tx_tready;
   logic                      m_axi_tx_tlast;
   logic [NUM_SRC-1:0]        grant;
   logic                      trunc_err;
   logic                      flush_err;
   state_t                    dbg_state;

   int tests_run;
   int tests_failed;

   // Source packet model: source i has src_len[i] beats, src_sent[i] accepted.
   int src_len  [NUM_SRC];
   int src_sent [NUM_SRC];

   // Observations taken mid-cycle, before the rising edge.
   logic [NUM_SRC-1:0] obs_grant;
   logic [NUM_SRC-1:0] obs_s_tready;
   logic [NUM_SRC-1:0] obs_s_tvalid;
   logic [15:0]        obs_tdata;
   logic [1:0]         obs_tkeep;
   logic               obs_tvalid;
   logic               obs_tlast;
   logic               obs_trunc;
   logic               obs_flush;
   logic [1:0]         obs_state;

   dnpcie_aurora_tx_arbiter #(
      .NUM_SRC       (NUM_SRC),
      .MAX_PKT_WORDS (MAXW)
   ) dut (
      .user_clk        (user_clk),
      .ur_ch_reset     (ur_ch_reset),
      .channel_up      (channel_up),
      .s_axis_tdata    (s_axis_tdata),
      .s_axis_tkeep    (s_axis_tkeep),
      .s_axis_tlast    (s_axis_tlast),
      .s_axis_tvalid   (s_axis_tvalid),
      .s_axis_tready   (s_axis_tready),
      .m_axi_tx_tdata  (m_axi_tx_tdata),
      .m_axi_tx_tkeep  (m_axi_tx_tkeep),
      .m_axi_tx_tvalid (m_axi_tx_tvalid),
      .m_axi_tx_tready (m_axi_tx_tready),
      .m_axi_tx_tlast  (m_axi_tx_tlast),
      .grant           (grant),
      .trunc_err       (trunc_err),
      .flush_err       (flush_err),
      .dbg_state       (dbg_state)
   );

   // Clock: 10 ns period.
   initial begin
      user_clk = 1'b0;
      forever #5 user_clk = ~user_clk;
   end

   function automatic logic [15:0] word_of(input int src, input int beat);
      return {4'(src), 4'hA, 8'(beat)};
   endfunction

   // Present each source's current beat from the packet model.
   task automatic drive_srcs();
      for (int i = 0; i < NUM_SRC; i++) begin
         if (src_sent[i] < src_len[i]) begin
            s_axis_tvalid[i]          = 1'b1;
            s_axis_tdata[16*i +: 16]  = word_of(i, src_sent[i]);
            s_axis_tlast[i]           = (src_sent[i] == src_len[i] - 1);
            s_axis_tkeep[2*i +: 2]    = (src_sent[i] == src_len[i] - 1) ? 2'b10 : 2'b11;
         end else begin
            s_axis_tvalid[i]          = 1'b0;
            s_axis_tdata[16*i +: 16]  = 16'h0000;
            s_axis_tlast[i]           = 1'b0;
            s_axis_tkeep[2*i +: 2]    = 2'b00;
         end
      end
   endtask

   // One clock cycle: drive at the falling edge, sample, cross the rising edge.
   task automatic cycle();
      drive_srcs();
      #1;
      obs_grant    = grant;
      obs_s_tready = s_axis_tready;
      obs_s_tvalid = s_axis_tvalid;
      obs_tdata    = m_axi_tx_tdata;
      obs_tkeep    = m_axi_tx_tkeep;
      obs_tvalid   = m_axi_tx_tvalid;
      obs_tlast    = m_axi_tx_tlast;
      obs_trunc    = trunc_err;
      obs_flush    = flush_err;
      obs_state    = dbg_state;
      @(posedge user_clk);
      for (int i = 0; i < NUM_SRC; i++) begin
         if (obs_s_tvalid[i] && obs_s_tready[i]) src_sent[i]++;
      end
      @(negedge user_clk);
   endtask

   task automatic test_reset();
      ur_ch_reset = 1'b1;
      cycle();
      cycle();
      ur_ch_reset = 1'b0;
      cycle();
      tests_run++;
      if ({obs_grant, obs_s_tready, obs_tvalid, obs_tlast, obs_trunc, obs_flush, obs_state} !==
          {4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, IDLE}) begin
         tests_failed++;
         $display("FAIL reset: grant=%b rdy=%b vld=%b last=%b trunc=%b flush=%b st=%0d, want all 0 / IDLE",
                  obs_grant, obs_s_tready, obs_tvalid, obs_tlast, obs_trunc, obs_flush, obs_state);
      end
   endtask

   task automatic test_round_robin();
      for (int i = 0; i < NUM_SRC; i++) begin
         src_len[i]  = 3;
         src_sent[i] = 0;
      end
      for (int p = 0; p < NUM_SRC; p++) begin
         cycle();
         tests_run++;
         if ({obs_grant, obs_tvalid, obs_state} !== {4'b0000, 1'b0, IDLE}) begin
            tests_failed++;
            $display("FAIL rr_gap p=%0d: grant=%b vld=%b st=%0d, want 0000/0/IDLE", p, obs_grant, obs_tvalid, obs_state);
         end
         for (int b = 0; b < 3; b++) begin
            cycle();
            tests_run++;
            if ({obs_grant, obs_s_tready, obs_tvalid, obs_tdata, obs_tlast, obs_tkeep, obs_trunc, obs_flush} !==
                {4'(1 << p), 4'(1 << p), 1'b1, word_of(p, b), (b == 2), ((b == 2) ? 2'b10 : 2'b11), 1'b0, 1'b0}) begin
               tests_failed++;
               $display("FAIL rr_beat p=%0d b=%0d: grant=%b rdy=%b vld=%b data=%h last=%b keep=%b, want grant=%b data=%h last=%b",
                        p, b, obs_grant, obs_s_tready, obs_tvalid, obs_tdata, obs_tlast, obs_tkeep,
                        4'(1 << p), word_of(p, b), (b == 2));
            end
         end
      end
      cycle();
      tests_run++;
      if ({obs_grant, obs_state} !== {4'b0000, IDLE}) begin
         tests_failed++;
         $display("FAIL rr_end: grant=%b st=%0d, want 0000/IDLE", obs_grant, obs_state);
      end
   endtask

   task automatic test_backpressure();
      int beats;
      int k;
      src_len[2]  = 4;
      src_sent[2] = 0;
      m_axi_tx_tready = 1'b1;
      cycle();
      beats = 0;
      k = 0;
      while (beats < 4 && k < 16) begin
         m_axi_tx_tready = (k % 2 == 0);
         cycle();
         tests_run++;
         if ({obs_grant, obs_s_tready, obs_tvalid, obs_tdata, obs_tlast} !==
             {4'b0100, (m_axi_tx_tready ? 4'b0100 : 4'b0000), 1'b1, word_of(2, beats), (beats == 3)}) begin
            tests_failed++;
            $display("FAIL bp_beat k=%0d: grant=%b rdy=%b vld=%b data=%h last=%b, want 0100 rdy=%b data=%h",
                     k, obs_grant, obs_s_tready, obs_tvalid, obs_tdata, obs_tlast,
                     (m_axi_tx_tready ? 4'b0100 : 4'b0000), word_of(2, beats));
         end
         if (m_axi_tx_tready) beats++;
         k++;
      end
      m_axi_tx_tready = 1'b1;
      tests_run++;
      if (k !== 7) begin
         tests_failed++;
         $display("FAIL bp_cycles: took %0d cycles, want 7", k);
      end
      cycle();
      tests_run++;
      if ({obs_grant, obs_s_tready, obs_state} !== {4'b0000, 4'b0000, IDLE}) begin
         tests_failed++;
         $display("FAIL bp_end: grant=%b rdy=%b st=%0d, want 0000/0000/IDLE", obs_grant, obs_s_tready, obs_state);
      end
   endtask

   task automatic test_truncation();
      src_len[1]  = 12;
      src_sent[1] = 0;
      cycle();
      for (int b = 0; b < MAXW; b++) begin
         cycle();
         tests_run++;
         if ({obs_grant, obs_tvalid, obs_tdata, obs_tlast, obs_trunc} !==
             {4'b0010, 1'b1, word_of(1, b), (b == MAXW - 1), 1'b0}) begin
            tests_failed++;
            $display("FAIL trunc_beat b=%0d: grant=%b vld=%b data=%h last=%b trunc=%b, want 0010/1/%h/%b/0",
                     b, obs_grant, obs_tvalid, obs_tdata, obs_tlast, obs_trunc, word_of(1, b), (b == MAXW - 1));
         end
      end
      for (int b = MAXW; b < 12; b++) begin
         cycle();
         tests_run++;
         if ({obs_tvalid, obs_s_tready, obs_state, obs_trunc} !== {1'b0, 4'b0010, FLUSH, (b == MAXW)}) begin
            tests_failed++;
            $display("FAIL trunc_flush b=%0d: vld=%b rdy=%b st=%0d trunc=%b, want 0/0010/FLUSH/%b",
                     b, obs_tvalid, obs_s_tready, obs_state, obs_trunc, (b == MAXW));
         end
      end
      cycle();
      tests_run++;
      if ({obs_grant, obs_state, obs_trunc} !== {4'b0000, IDLE, 1'b0}) begin
         tests_failed++;
         $display("FAIL trunc_end: grant=%b st=%0d trunc=%b, want 0000/IDLE/0", obs_grant, obs_state, obs_trunc);
      end
   endtask

   task automatic test_link_drop();
      src_len[3]  = 10;
      src_sent[3] = 0;
      cycle();
      for (int b = 0; b < 3; b++) begin
         if (b == 2) channel_up = 1'b0;
         cycle();
         tests_run++;
         if ({obs_grant, obs_tvalid, obs_tdata, obs_flush} !== {4'b1000, 1'b1, word_of(3, b), 1'b0}) begin
            tests_failed++;
            $display("FAIL drop_beat b=%0d: grant=%b vld=%b data=%h flush=%b, want 1000/1/%h/0",
                     b, obs_grant, obs_tvalid, obs_tdata, obs_flush, word_of(3, b));
         end
      end
      for (int b = 3; b < 10; b++) begin
         cycle();
         tests_run++;
         if ({obs_tvalid, obs_s_tready, obs_state, obs_flush} !== {1'b0, 4'b1000, FLUSH, (b == 3)}) begin
            tests_failed++;
            $display("FAIL drop_drain b=%0d: vld=%b rdy=%b st=%0d flush=%b, want 0/1000/FLUSH/%b",
                     b, obs_tvalid, obs_s_tready, obs_state, obs_flush, (b == 3));
         end
      end
      src_len[0]  = 2;
      src_sent[0] = 0;
      for (int c = 0; c < 3; c++) begin
         cycle();
         tests_run++;
         if ({obs_grant, obs_tvalid, obs_s_tready, obs_state, obs_flush} !== {4'b0000, 1'b0, 4'b0000, IDLE, 1'b0}) begin
            tests_failed++;
            $display("FAIL drop_hold c=%0d: grant=%b vld=%b rdy=%b st=%0d flush=%b, want 0000/0/0000/IDLE/0",
                     c, obs_grant, obs_tvalid, obs_s_tready, obs_state, obs_flush);
         end
      end
      channel_up = 1'b1;
      cycle();
      for (int b = 0; b < 2; b++) begin
         cycle();
         tests_run++;
         if ({obs_grant, obs_tvalid, obs_tdata} !== {4'b0001, 1'b1, word_of(0, b)}) begin
            tests_failed++;
            $display("FAIL drop_resume b=%0d: grant=%b vld=%b data=%h, want 0001/1/%h",
                     b, obs_grant, obs_tvalid, obs_tdata, word_of(0, b));
         end
      end
      cycle();
   endtask

   task automatic test_mid_reset();
      src_len[2]  = 8;
      src_sent[2] = 0;
      cycle();
      for (int b = 0; b < 4; b++) begin
         cycle();
         tests_run++;
         if ({obs_grant, obs_tdata} !== {4'b0100, word_of(2, b)}) begin
            tests_failed++;
            $display("FAIL rst_beat b=%0d: grant=%b data=%h, want 0100/%h", b, obs_grant, obs_tdata, word_of(2, b));
         end
      end
      ur_ch_reset = 1'b1;
      cycle();
      ur_ch_reset = 1'b0;
      src_len[0]  = 2;
      src_sent[0] = 0;
      src_len[1]  = 2;
      src_sent[1] = 0;
      cycle();
      tests_run++;
      if ({obs_grant, obs_s_tready, obs_tvalid, obs_state} !== {4'b0000, 4'b0000, 1'b0, IDLE}) begin
         tests_failed++;
         $display("FAIL rst_after: grant=%b rdy=%b vld=%b st=%0d, want 0000/0000/0/IDLE",
                  obs_grant, obs_s_tready, obs_tvalid, obs_state);
      end
      cycle();
      tests_run++;
      if ({obs_grant, obs_tvalid, obs_tdata} !== {4'b0001, 1'b1, word_of(0, 0)}) begin
         tests_failed++;
         $display("FAIL rst_first: grant=%b vld=%b data=%h, want 0001/1/%h", obs_grant, obs_tvalid, obs_tdata, word_of(0, 0));
      end
   endtask

   initial begin
      tests_run       = 0;
      tests_failed    = 0;
      ur_ch_reset     = 1'b1;
      channel_up      = 1'b1;
      m_axi_tx_tready = 1'b1;
      s_axis_tdata    = '0;
      s_axis_tkeep    = '0;
      s_axis_tlast    = '0;
      s_axis_tvalid   = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         src_len[i]  = 0;
         src_sent[i] = 0;
      end
      @(negedge user_clk);
      test_reset();
      test_round_robin();
      test_backpressure();
      test_truncation();
      test_link_drop();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
